imem_load_ctrl: RTL and testbench
=================================

// Module: imem_load_ctrl
// PURPOSE
//  Sequences run-time programming of the instruction memory from an external byte stream (UART/debug).
//  Arbitrates imem between CPU fetch (normal run) and the loader (program mode).
//  Holds the core in reset while loading. Releases it at PC 0 once the image is written.
//  Sits between the top-level byte source, the core's fetch port and the imem write port.
// PARAMETERS
//  DEPTH  127            imem depth in 32-bit words; word indices >= DEPTH are never written
//  AW     7              imem word-address width, ceil(log2(DEPTH))
//  NOP    32'h00000013   instruction returned to fetch while loading (addi x0,x0,0)
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  reset      in   1   asynchronous, active-high
//  start      in   1   1-cycle pulse: enter program mode (ignored unless IDLE)
//  abort      in   1   abandon load, return to IDLE (no done pulse)
//  in_valid   in   1   byte source has data
//  in_data    in   8   byte payload
//  in_ready   out  1   loader accepts byte; transfer = in_valid & in_ready
//  pc_a       in   32  core fetch byte address
//  fetch_rd   out  32  instruction to core: imem_rd in IDLE, NOP otherwise
//  imem_a     out  32  imem read address = pc_a (pure passthrough)
//  imem_rd    in   32  imem read data
//  imem_we    out  1   imem write strobe
//  imem_wa    out  AW  imem write word index
//  imem_wd    out  32  imem write data
//  core_hold  out  1   core reset/stall; 1 in every state except IDLE
//  done       out  1   1-cycle pulse when load completes
//  err        out  1   sticky overflow flag; cleared by accepted start or reset
// BEHAVIOUR
//  Reset (async): state=IDLE, in_ready=0, imem_we=0, imem_wa=0, imem_wd=0, done=0, err=0,
//   internal count/word_idx/byte_idx=0. core_hold=0 (core runs from existing imem contents).
//  Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N*4 bytes, each word LSB first.
//  States:
//   IDLE   : in_ready=0; start -> LEN_LO, err<=0, word_idx<=0, byte_idx<=0
//   LEN_LO : in_ready=1; transfer -> count[7:0]<=in_data, LEN_HI
//   LEN_HI : in_ready=1; transfer -> count[15:8]<=in_data; N==0 -> FINISH else DATA
//   DATA   : in_ready=1; transfer shifts byte into word buffer at lane byte_idx, byte_idx++ (mod 4)
//            on 4th byte: next cycle imem_we=1, imem_wa=word_idx[AW-1:0], imem_wd=assembled word,
//            provided word_idx<DEPTH; else no write, err<=1. word_idx++.
//            on 4th byte of word N-1 -> FINISH
//   FINISH : in_ready=0; done=1 for exactly this cycle; -> IDLE (core_hold drops next cycle)
//  imem_we, imem_wa and imem_wd are registered. Write occurs 1 cycle after the 4th byte's transfer cycle.
//  imem_we is a 1-cycle pulse. imem_wa/imem_wd hold their value otherwise.
//  Last write and done are in the same cycle (FINISH). The core leaves hold the cycle after FINISH.
//  in_valid low stalls the FSM indefinitely; no timeout.
//  Bytes presented in IDLE/FINISH are not consumed (in_ready=0).
//  abort (any non-IDLE state): -> IDLE next cycle. Suppress any pending write and done.
//   err is unchanged. Partially written imem is left as is.
//  abort has priority over a simultaneous byte transfer. start and abort both high in IDLE: stay IDLE.
//  start while not IDLE is ignored (no restart, no err change).
//  fetch_rd is combinational: state==IDLE ? imem_rd : NOP. No added fetch latency.
//  Counters: word_idx is 16 bits and never wraps within a legal N (<=65535).
//   Writes only use the low AW bits, gated by word_idx<DEPTH.
// TESTING
//  Load N=3 words 0x00500093,0x00100113,0x0000006F -> 3 imem_we pulses wa=0,1,2 with exact wd; done 1 cycle; err=0.
//  Same load with in_valid toggled every other cycle -> identical writes; core_hold=1 throughout; fetch_rd=NOP.
//  N=0 (bytes 00 00) -> no imem_we; done 1 cycle after LEN_HI; core_hold falls next cycle.
//  DEPTH=4, N=6 -> writes wa=0..3 only; err=1 after 5th word; done still pulses; err cleared by next start.
//  reset or abort asserted after 2 data bytes of word 1 -> IDLE, no imem_we, no done, core_hold=0, in_ready=0.
//  start pulsed during DATA -> ignored; abort+byte same cycle -> byte not counted; fetch_rd=imem_rd in IDLE.

Source files
------------

// File: rtl/imem_load_ctrl_if.sv
// Bundles the loader's byte stream, control pulses, core fetch port and imem ports.
// The controller takes the master modport and its environment takes the slave modport.
interface imem_load_ctrl_if #(
    parameter int unsigned AW = 7
);
    logic          start;
    logic          abort;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic [31:0]   pc_a;
    logic [31:0]   fetch_rd;
    logic [31:0]   imem_a;
    logic [31:0]   imem_rd;
    logic          imem_we;
    logic [AW-1:0] imem_wa;
    logic [31:0]   imem_wd;
    logic          core_hold;
    logic          done;
    logic          err;

    modport master (
        input  start, abort, in_valid, in_data, pc_a, imem_rd,
        output in_ready, fetch_rd, imem_a, imem_we, imem_wa, imem_wd, core_hold, done, err
    );

    modport slave (
        output start, abort, in_valid, in_data, pc_a, imem_rd,
        input  in_ready, fetch_rd, imem_a, imem_we, imem_wa, imem_wd, core_hold, done, err
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// Loads a length-prefixed little-endian word image from a byte stream into imem while
// holding the core; the core fetches NOPs until the load finishes or is aborted.
module imem_load_ctrl #(
    parameter int unsigned DEPTH = 127,
    parameter int unsigned AW    = 7,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input logic              clk,
    input logic              reset,
    imem_load_ctrl_if.master bus
);
    typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StFinish} state_e;

    state_e      state;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic        xfer;

    assign xfer          = bus.in_valid & bus.in_ready;
    assign bus.in_ready  = (state == StLenLo) || (state == StLenHi) || (state == StData);
    assign bus.core_hold = (state != StIdle);
    assign bus.done      = (state == StFinish);
    assign bus.fetch_rd  = (state == StIdle) ? bus.imem_rd : NOP;
    assign bus.imem_a    = bus.pc_a;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            count       <= '0;
            word_idx    <= '0;
            byte_idx    <= '0;
            word_buf    <= '0;
            bus.imem_we <= 1'b0;
            bus.imem_wa <= '0;
            bus.imem_wd <= '0;
            bus.err     <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            // Abort wins over any byte offered in the same cycle.
            if (state != StIdle && bus.abort) begin
                state <= StIdle;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (bus.start && !bus.abort) begin
                            state    <= StLenLo;
                            bus.err  <= 1'b0;
                            word_idx <= '0;
                            byte_idx <= '0;
                        end
                    end
                    StLenLo: begin
                        if (xfer) begin
                            count[7:0] <= bus.in_data;
                            state      <= StLenHi;
                        end
                    end
                    StLenHi: begin
                        if (xfer) begin
                            count[15:8] <= bus.in_data;
                            state <= ({bus.in_data, count[7:0]} == 16'd0) ? StFinish : StData;
                        end
                    end
                    StData: begin
                        if (xfer) begin
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx != 2'd3) begin
                                word_buf[{byte_idx, 3'b000} +: 8] <= bus.in_data;
                            end else begin
                                // Words past the end of imem are dropped and flagged.
                                if (32'(word_idx) < DEPTH) begin
                                    bus.imem_we <= 1'b1;
                                    bus.imem_wa <= word_idx[AW-1:0];
                                    bus.imem_wd <= {bus.in_data, word_buf};
                                end else begin
                                    bus.err <= 1'b1;
                                end
                                word_idx <= word_idx + 16'd1;
                                if (word_idx == count - 16'd1) begin
                                    state <= StFinish;
                                end
                            end
                        end
                    end
                    StFinish: state <= StIdle;
                    default:  state <= StIdle;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_load_ctrl.sv
// Drives two loaders (deep and 4-word imem) with one stream and checks both every cycle
// against a byte-counting model, plus literal expectations for the directed loads.
module tb_imem_load_ctrl;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        bit          active;
        bit          fin;
        int          nbytes;
        int          n;
        logic [31:0] word;
        bit          we;
        int          wa;
        logic [31:0] wd;
        bit          err;
    } mdl_t;

    typedef struct {
        int          wa;
        logic [31:0] wd;
    } wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    mdl_t m0, m1;
    wr_t  wlog0[$], wlog1[$];
    int   done0 = 0, done1 = 0;
    logic [31:0] prog3[$] = '{32'h00500093, 32'h00100113, 32'h0000006F};

    always #5 clk = ~clk;

    imem_load_ctrl_if #(.AW(7)) bus0 ();
    imem_load_ctrl_if #(.AW(2)) bus1 ();

    assign bus1.start    = bus0.start;
    assign bus1.abort    = bus0.abort;
    assign bus1.in_valid = bus0.in_valid;
    assign bus1.in_data  = bus0.in_data;
    assign bus1.pc_a     = bus0.pc_a;
    assign bus1.imem_rd  = bus0.imem_rd;

    imem_load_ctrl #(.DEPTH(127), .AW(7), .NOP(NOP)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.master)
    );
    imem_load_ctrl #(.DEPTH(4), .AW(2), .NOP(NOP)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.master)
    );

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.active = 0; m.fin = 0; m.nbytes = 0; m.n = 0; m.word = '0;
        m.we = 0; m.wa = 0; m.wd = '0; m.err = 0;
        return m;
    endfunction

    // Progress is a count of accepted bytes: 0/1 are the length, then 4 per word.
    function automatic mdl_t mdl_step(mdl_t m, int depth, bit start, bit abort, bit valid,
                                      logic [7:0] data);
        mdl_t n;
        int   d, w, lane;
        n    = m;
        n.we = 0;
        if (!m.active) begin
            if (start && !abort) begin
                n.active = 1; n.fin = 0; n.nbytes = 0; n.err = 0;
            end
        end else if (abort || m.fin) begin
            n.active = 0; n.fin = 0;
        end else if (valid) begin
            if (m.nbytes == 0) begin
                n.n = int'(data);
            end else if (m.nbytes == 1) begin
                n.n   = m.n + 256 * int'(data);
                n.fin = (n.n == 0);
            end else begin
                d = m.nbytes - 2; w = d / 4; lane = d % 4;
                n.word[lane*8 +: 8] = data;
                if (lane == 3) begin
                    if (w < depth) begin
                        n.we = 1; n.wa = w; n.wd = n.word;
                    end else begin
                        n.err = 1;
                    end
                    n.fin = (w == m.n - 1);
                end
            end
            n.nbytes = m.nbytes + 1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m0 <= mdl_reset();
            m1 <= mdl_reset();
        end else begin
            m0 <= mdl_step(m0, 127, bus0.start, bus0.abort, bus0.in_valid, bus0.in_data);
            m1 <= mdl_step(m1, 4, bus0.start, bus0.abort, bus0.in_valid, bus0.in_data);
        end
    end

    task automatic chk(input int id, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (dut%0d) t=%0t: got %h, want %h", nm, id, $time, act, exp);
        end
    endtask

    task automatic cmp(input int id, input mdl_t m, input logic rdy, input logic [31:0] frd,
                       input logic [31:0] ia, input logic we, input logic [31:0] wa,
                       input logic [31:0] wd, input logic hold, input logic dn, input logic er);
        chk(id, "in_ready", 32'(rdy), 32'(m.active && !m.fin));
        chk(id, "fetch_rd", frd, m.active ? NOP : bus0.imem_rd);
        chk(id, "imem_a", ia, bus0.pc_a);
        chk(id, "imem_we", 32'(we), 32'(m.we));
        chk(id, "imem_wa", wa, 32'(m.wa));
        chk(id, "imem_wd", wd, m.wd);
        chk(id, "core_hold", 32'(hold), 32'(m.active));
        chk(id, "done", 32'(dn), 32'(m.fin));
        chk(id, "err", 32'(er), 32'(m.err));
    endtask

    always @(negedge clk) begin
        cmp(0, m0, bus0.in_ready, bus0.fetch_rd, bus0.imem_a, bus0.imem_we, 32'(bus0.imem_wa),
            bus0.imem_wd, bus0.core_hold, bus0.done, bus0.err);
        cmp(1, m1, bus1.in_ready, bus1.fetch_rd, bus1.imem_a, bus1.imem_we, 32'(bus1.imem_wa),
            bus1.imem_wd, bus1.core_hold, bus1.done, bus1.err);
        if (bus0.imem_we === 1'b1) wlog0.push_back('{int'(bus0.imem_wa), bus0.imem_wd});
        if (bus1.imem_we === 1'b1) wlog1.push_back('{int'(bus1.imem_wa), bus1.imem_wd});
        if (bus0.done === 1'b1) done0++;
        if (bus1.done === 1'b1) done1++;
    end

    always @(posedge clk) begin
        #2;
        bus0.pc_a    = $urandom;
        bus0.imem_rd = $urandom;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wlog0.delete(); wlog1.delete(); done0 = 0; done1 = 0;
    endtask

    task automatic pulse_start();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
    endtask

    task automatic push(input logic [7:0] b, input bit gap);
        bit ok = 0;
        if (gap) begin
            bus0.in_valid = 1'b0;
            tick();
        end
        bus0.in_valid = 1'b1;
        bus0.in_data  = b;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = bus0.in_ready;
            tick();
        end
        bus0.in_valid = 1'b0;
        bus0.in_data  = 8'($urandom);
        if (!ok) chk(9, "push_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_word(input logic [31:0] w, input int nb, input bit gap);
        for (int l = 0; l < nb; l++) push(w[8*l +: 8], gap);
    endtask

    task automatic load(input logic [31:0] w[$], input bit gap);
        int n = w.size();
        pulse_start();
        push(8'(n), gap);
        push(8'(n >> 8), gap);
        foreach (w[i]) push_word(w[i], 4, gap);
        repeat (3) tick();
    endtask

    // Expected writes: word i lands at index i, only below the imem depth.
    task automatic check_writes(input string nm, input wr_t got[$], input logic [31:0] w[$],
                                input int depth);
        int ne = (w.size() < depth) ? w.size() : depth;
        chk(9, {nm, "_count"}, 32'(got.size()), 32'(ne));
        for (int i = 0; i < ne && i < got.size(); i++) begin
            chk(9, {nm, "_wa"}, 32'(got[i].wa), 32'(i));
            chk(9, {nm, "_wd"}, got[i].wd, w[i]);
        end
    endtask

    initial begin
        logic [31:0] ws[$];
        logic [31:0] one[$];
        logic [31:0] none[$];
        bus0.start = 0; bus0.abort = 0; bus0.in_valid = 0; bus0.in_data = 0;
        bus0.pc_a = 0; bus0.imem_rd = 0;
        #1 reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk(9, "rst_hold", 32'(bus0.core_hold), 32'd0);
        chk(9, "rst_ready", 32'(bus0.in_ready), 32'd0);
        chk(9, "rst_wa", 32'(bus0.imem_wa), 32'd0);
        chk(9, "rst_wd", bus0.imem_wd, 32'd0);
        chk(9, "rst_err", 32'(bus0.err), 32'd0);

        for (int g = 0; g < 2; g++) begin
            clear_logs();
            load(prog3, g[0]);
            check_writes("prog3", wlog0, prog3, 127);
            chk(9, "prog3_done", 32'(done0), 32'd1);
            chk(9, "prog3_err", 32'(bus0.err), 32'd0);
            chk(9, "idle_fetch", bus0.fetch_rd, bus0.imem_rd);
        end

        clear_logs();
        load(none, 1'b0);
        chk(9, "n0_writes", 32'(wlog0.size()), 32'd0);
        chk(9, "n0_done", 32'(done0), 32'd1);

        clear_logs();
        ws.delete();
        for (int i = 0; i < 6; i++) ws.push_back($urandom);
        load(ws, 1'b0);
        check_writes("n6_deep", wlog0, ws, 127);
        check_writes("n6_small", wlog1, ws, 4);
        chk(9, "n6_err_small", 32'(bus1.err), 32'd1);
        chk(9, "n6_err_deep", 32'(bus0.err), 32'd0);
        chk(9, "n6_done_small", 32'(done1), 32'd1);
        pulse_start();
        chk(9, "restart_err", 32'(bus1.err), 32'd0);
        bus0.abort = 1'b1; tick(); bus0.abort = 1'b0; tick();

        // Abort, then reset, after two data bytes of word 1.
        for (int k = 0; k < 2; k++) begin
            pulse_start();
            push(8'd2, 1'b0); push(8'd0, 1'b0);
            push_word(32'hA1B2C3D4, 4, 1'b0);
            push_word(32'h11223344, 2, 1'b0);
            clear_logs();
            if (k == 0) bus0.abort = 1'b1;
            else reset = 1'b1;
            tick();
            bus0.abort = 1'b0; reset = 1'b0;
            repeat (3) tick();
            chk(9, "cut_writes", 32'(wlog0.size()), 32'd0);
            chk(9, "cut_done", 32'(done0), 32'd0);
            chk(9, "cut_hold", 32'(bus0.core_hold), 32'd0);
            chk(9, "cut_ready", 32'(bus0.in_ready), 32'd0);
        end

        clear_logs();
        pulse_start();
        push(8'd1, 1'b0); push(8'd0, 1'b0);
        push_word(32'hCAFEF00D, 2, 1'b0);
        pulse_start();
        push(8'hFE, 1'b0); push(8'hCA, 1'b0);
        repeat (3) tick();
        one = '{32'hCAFEF00D};
        check_writes("start_in_data", wlog0, one, 127);

        clear_logs();
        pulse_start();
        push(8'd1, 1'b0); push(8'd0, 1'b0);
        push_word(32'h55667788, 3, 1'b0);
        bus0.in_valid = 1'b1; bus0.in_data = 8'h55; bus0.abort = 1'b1;
        tick();
        bus0.in_valid = 1'b0; bus0.abort = 1'b0;
        repeat (3) tick();
        chk(9, "abort_byte_writes", 32'(wlog0.size()), 32'd0);
        chk(9, "abort_byte_hold", 32'(bus0.core_hold), 32'd0);

        for (int r = 0; r < 12; r++) begin
            clear_logs();
            ws.delete();
            for (int i = 0; i < int'($urandom_range(0, 7)); i++) ws.push_back($urandom);
            load(ws, 1'($urandom));
            check_writes("rand_load", wlog0, ws, 127);
            chk(9, "rand_done", 32'(done0), 32'd1);
        end

        for (int c = 0; c < 3000; c++) begin
            bus0.in_valid = 1'($urandom);
            bus0.in_data  = 8'($urandom);
            bus0.start    = ($urandom % 8) == 0;
            bus0.abort    = ($urandom % 30) == 0;
            reset         = ($urandom % 600) == 0;
            tick();
        end
        bus0.in_valid = 0; bus0.start = 0; bus0.abort = 0; reset = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
